// File: rtl/spi_reg_slave.sv
// spi_reg_slave
//   SPI mode-0 slave that turns host transactions into single-cycle register
//   read/write strobes in the clk domain. The first byte carries the direction
//   in bit 7 (1=write, 0=read) and the register number in bits 6:0. Every byte
//   after it is one data byte, and regnum optionally auto-increments.
//
//   state | meaning
//   IDLE  | deselected, or waiting for a fresh ss falling edge after rst
//   ADDR  | shifting in the address/direction byte
//   DATA  | shifting data bytes (write: strobe write, read: prefetch next)
//
// Ports
//   clk            system clock
//   rst            synchronous active-high reset
//   ss, sck, mosi  SPI inputs, asynchronous to clk
//   miso           SPI data out, 0 while deselected
//   regnum         current register number
//   regdata_read   read data for regnum (combinational from regnum)
//   regdata_write  write data, valid while write=1
//   read           1-cycle strobe, regdata_read is captured in this cycle
//   write          1-cycle strobe, register regnum <= regdata_write
module spi_reg_slave #(
   parameter int SYNC_STAGES = 2,
   parameter bit AUTO_INC    = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ss,
   input  logic       sck,
   input  logic       mosi,
   output logic       miso,
   output logic [6:0] regnum,
   input  logic [7:0] regdata_read,
   output logic [7:0] regdata_write,
   output logic       read,
   output logic       write
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] ss_sync;
   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   ss_q;
   logic                   sck_q;
   logic [2:0]             bit_cnt;
   logic [6:0]             rx_shift;
   logic [7:0]             tx_shift;
   logic                   wr_mode;
   logic                   inc_pend;

   logic       ss_s, sck_s, mosi_s;
   logic       ss_fall, ss_rise, sck_rise, sck_fall, byte_done;
   logic [7:0] rx_byte;

   assign ss_s      = ss_sync[SYNC_STAGES-1];
   assign sck_s     = sck_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign ss_fall   = ss_q & ~ss_s;
   assign ss_rise   = ~ss_q & ss_s;
   assign sck_rise  = ~sck_q & sck_s;
   assign sck_fall  = sck_q & ~sck_s;
   assign byte_done = sck_rise && (bit_cnt == 3'd7);
   assign rx_byte   = {rx_shift, mosi_s};

   always_ff @(posedge clk) begin
      if (rst) begin
         // ss chain and its edge register reset low: if ss is already low when
         // rst drops no falling edge appears, so the FSM waits for a new one.
         ss_sync       <= '0;
         sck_sync      <= '0;
         mosi_sync     <= '0;
         ss_q          <= 1'b0;
         sck_q         <= 1'b0;
         state         <= IDLE;
         bit_cnt       <= 3'd0;
         rx_shift      <= 7'd0;
         tx_shift      <= 8'd0;
         wr_mode       <= 1'b0;
         inc_pend      <= 1'b0;
         miso          <= 1'b0;
         regnum        <= 7'd0;
         regdata_write <= 8'd0;
         read          <= 1'b0;
         write         <= 1'b0;
      end else begin
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         ss_q      <= ss_s;
         sck_q     <= sck_s;
         read      <= 1'b0;
         write     <= 1'b0;
         miso      <= (state != IDLE) && !ss_s && tx_shift[7];

         // Increment lands the cycle after the write strobe so the register
         // file sees a stable regnum while write is high.
         if (write && AUTO_INC)
            regnum <= regnum + 7'd1;

         // Read-mode data byte finished: bump regnum, then prefetch next cycle.
         if (inc_pend) begin
            inc_pend <= 1'b0;
            read     <= 1'b1;
            if (AUTO_INC)
               regnum <= regnum + 7'd1;
         end

         case (state)
            IDLE: begin
               if (ss_fall) begin
                  state    <= ADDR;
                  bit_cnt  <= 3'd0;
                  tx_shift <= 8'd0;
               end
            end
            ADDR, DATA: begin
               if (ss_rise) begin
                  state    <= IDLE;
                  inc_pend <= 1'b0;
                  read     <= 1'b0;
               end else begin
                  if (sck_rise) begin
                     rx_shift <= rx_byte[6:0];
                     bit_cnt  <= bit_cnt + 3'd1;
                  end
                  // No shift on the first falling edge of a byte: the freshly
                  // loaded MSB must stay on miso for the next rising edge.
                  if (sck_fall && (bit_cnt != 3'd0))
                     tx_shift <= {tx_shift[6:0], 1'b0};
                  if (byte_done) begin
                     if (state == ADDR) begin
                        regnum  <= rx_byte[6:0];
                        wr_mode <= rx_byte[7];
                        read    <= ~rx_byte[7];
                        state   <= DATA;
                     end else if (wr_mode) begin
                        write         <= 1'b1;
                        regdata_write <= rx_byte;
                     end else begin
                        inc_pend <= 1'b1;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase

         // regnum already points at the target register while read is high.
         if (read)
            tx_shift <= regdata_read;
      end
   end

endmodule

// File: tb/tb_spi_reg_slave.sv
module tb_spi_reg_slave;

   localparam int HALF = 100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ss = 1'b1;
   logic       sck = 1'b0;
   logic       mosi = 1'b0;
   logic       miso;
   logic [6:0] regnum;
   logic [7:0] regdata_read;
   logic [7:0] regdata_write;
   logic       read;
   logic       write;

   int checks = 0;
   int errors = 0;

   int         wr_n = 0;
   int         rd_n = 0;
   bit         overlap = 1'b0;
   logic [6:0] wr_addr [16];
   logic [7:0] wr_data [16];

   always #5 clk = ~clk;

   // Register file model: reg 0 holds 0x10, others hold regnum ^ 0xC3.
   assign regdata_read = (regnum == 7'h00) ? 8'h10 : ({1'b0, regnum} ^ 8'hC3);

   spi_reg_slave #(.SYNC_STAGES(2), .AUTO_INC(1'b1)) dut (
      .clk(clk), .rst(rst), .ss(ss), .sck(sck), .mosi(mosi), .miso(miso),
      .regnum(regnum), .regdata_read(regdata_read), .regdata_write(regdata_write),
      .read(read), .write(write)
   );

   always @(negedge clk) begin
      if (write) begin
         if (wr_n < 16) begin
            wr_addr[wr_n] = regnum;
            wr_data[wr_n] = regdata_write;
         end
         wr_n = wr_n + 1;
      end
      if (read) rd_n = rd_n + 1;
      if (read && write) overlap = 1'b1;
   end

   task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
      r = 8'h00;
      for (int i = 7; i > 7 - n; i--) begin
         mosi = b[i];
         #(HALF);
         r[i] = miso;
         sck = 1'b1;
         #(HALF);
         sck = 1'b0;
      end
   endtask

   task automatic ss_begin();
      ss = 1'b0;
      #(HALF);
   endtask

   task automatic ss_end();
      #(HALF);
      ss = 1'b1;
      #(2*HALF);
   endtask

   task automatic test_reset();
      logic [7:0] r;
      int wb, rb;
      rst = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (regnum !== 7'h00) begin errors++; $display("FAIL reset_regnum got %h want 00", regnum); end
      checks++; if (regdata_write !== 8'h00) begin errors++; $display("FAIL reset_wdata got %h want 00", regdata_write); end
      checks++; if (read !== 1'b0 || write !== 1'b0) begin errors++; $display("FAIL reset_strobes got r=%b w=%b want 0 0", read, write); end
      checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", miso); end
      wb = wr_n; rb = rd_n;
      spi_bits(8'hA5, 8, r);
      spi_bits(8'h3C, 8, r);
      checks++; if (r !== 8'h00) begin errors++; $display("FAIL idle_miso got %h want 00", r); end
      checks++; if (wr_n != wb || rd_n != rb) begin errors++; $display("FAIL idle_strobes got w=%0d r=%0d want 0 0", wr_n - wb, rd_n - rb); end
   endtask

   task automatic test_write();
      logic [7:0] r;
      int wb;
      wb = wr_n;
      ss_begin();
      spi_bits(8'h8D, 8, r);
      spi_bits(8'h5A, 8, r);
      checks++; if (r !== 8'h00) begin errors++; $display("FAIL wr_miso got %h want 00", r); end
      ss_end();
      checks++; if (wr_n - wb != 1) begin errors++; $display("FAIL wr_count got %0d want 1", wr_n - wb); end
      else begin
         checks++; if (wr_addr[wb] !== 7'h0D || wr_data[wb] !== 8'h5A) begin errors++; $display("FAIL wr_pair got %h/%h want 0d/5a", wr_addr[wb], wr_data[wb]); end
      end
      checks++; if (regnum !== 7'h0E) begin errors++; $display("FAIL wr_regnum got %h want 0e", regnum); end
   endtask

   task automatic test_read0();
      logic [7:0] r;
      int rb, wb;
      rb = rd_n; wb = wr_n;
      ss_begin();
      spi_bits(8'h00, 8, r);
      checks++; if (r !== 8'h00) begin errors++; $display("FAIL rd_addr_miso got %h want 00", r); end
      spi_bits(8'h00, 8, r);
      checks++; if (r !== 8'h10) begin errors++; $display("FAIL rd_miso got %h want 10", r); end
      ss_end();
      checks++; if (rd_n - rb != 2) begin errors++; $display("FAIL rd_count got %0d want 2", rd_n - rb); end
      checks++; if (wr_n != wb) begin errors++; $display("FAIL rd_no_write got %0d want 0", wr_n - wb); end
      checks++; if (regnum !== 7'h01) begin errors++; $display("FAIL rd_regnum got %h want 01", regnum); end
   endtask

   task automatic test_wrap();
      logic [7:0] r;
      int wb;
      wb = wr_n;
      ss_begin();
      spi_bits(8'hFF, 8, r);
      spi_bits(8'h11, 8, r);
      checks++; if (regnum !== 7'h00) begin errors++; $display("FAIL wrap_regnum got %h want 00", regnum); end
      spi_bits(8'h22, 8, r);
      ss_end();
      checks++; if (wr_n - wb != 2) begin errors++; $display("FAIL wrap_count got %0d want 2", wr_n - wb); end
      else begin
         checks++; if (wr_addr[wb] !== 7'h7F || wr_data[wb] !== 8'h11) begin errors++; $display("FAIL wrap_w0 got %h/%h want 7f/11", wr_addr[wb], wr_data[wb]); end
         checks++; if (wr_addr[wb+1] !== 7'h00 || wr_data[wb+1] !== 8'h22) begin errors++; $display("FAIL wrap_w1 got %h/%h want 00/22", wr_addr[wb+1], wr_data[wb+1]); end
      end
      checks++; if (regnum !== 7'h01) begin errors++; $display("FAIL wrap_end got %h want 01", regnum); end
   endtask

   task automatic test_short_byte();
      logic [7:0] r;
      int wb;
      wb = wr_n;
      ss_begin();
      spi_bits(8'h85, 8, r);
      spi_bits(8'hF0, 4, r);
      ss_end();
      checks++; if (wr_n != wb) begin errors++; $display("FAIL short_write got %0d want 0", wr_n - wb); end
      checks++; if (regnum !== 7'h05) begin errors++; $display("FAIL short_regnum got %h want 05", regnum); end
      ss_begin();
      spi_bits(8'h82, 8, r);
      spi_bits(8'h33, 8, r);
      ss_end();
      checks++; if (wr_n - wb != 1) begin errors++; $display("FAIL short_next_count got %0d want 1", wr_n - wb); end
      else begin
         checks++; if (wr_addr[wb] !== 7'h02 || wr_data[wb] !== 8'h33) begin errors++; $display("FAIL short_next got %h/%h want 02/33", wr_addr[wb], wr_data[wb]); end
      end
      checks++; if (regnum !== 7'h03) begin errors++; $display("FAIL short_next_regnum got %h want 03", regnum); end
   endtask

   task automatic test_rst_mid();
      logic [7:0] r;
      int rb;
      ss_begin();
      spi_bits(8'h03, 8, r);
      spi_bits(8'h00, 8, r);
      checks++; if (r !== 8'hC0) begin errors++; $display("FAIL mid_rd got %h want c0", r); end
      spi_bits(8'h00, 4, r);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (regnum !== 7'h00 || regdata_write !== 8'h00) begin errors++; $display("FAIL mid_rst_regs got %h/%h want 00/00", regnum, regdata_write); end
      checks++; if (miso !== 1'b0 || read !== 1'b0 || write !== 1'b0) begin errors++; $display("FAIL mid_rst_outs got m=%b r=%b w=%b want 0", miso, read, write); end
      rb = rd_n;
      spi_bits(8'h00, 8, r);
      checks++; if (r !== 8'h00 || rd_n != rb || regnum !== 7'h00) begin errors++; $display("FAIL mid_hold got miso=%h reads=%0d regnum=%h want 00 0 00", r, rd_n - rb, regnum); end
      ss = 1'b1;
      #(4*HALF);
      test_read0();
   endtask

   initial begin
      test_reset();
      test_write();
      test_read0();
      test_wrap();
      test_short_byte();
      test_rst_mid();
      checks++; if (overlap) begin errors++; $display("FAIL strobe_overlap got 1 want 0"); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
